ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the shared 32-bit data Ram (word/byte access, G-bit byte address).
- Requester 0 is the CPU data port; requester 1 is the DMA/video port.
- Each requester gets a single-transaction req/ack handshake. The block registers address, write data, write enable and byte mode, drives the Ram for exactly one cycle, captures read data and returns it with a one-cycle ack.

Parameters:
- G, 18, Ram byte-address width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- req0_i / req1_i  input  1  request from requester 0 / 1.
- we0_i / we1_i  input  1  1 = write, 0 = read.
- byte0_i / byte1_i  input  1  byte-mode access.
- addr0_i / addr1_i  input  G  byte address.
- wdata0_i / wdata1_i  input  32  write data; byte mode uses [7:0].
- ack0_o / ack1_o  output  1  one-cycle completion pulse.
- err_o  output  1  valid with ack; misaligned word access.
- rdata_o  output  32  read data, valid with ack (shared by both requesters).
- gnt_o  output  2  one-hot current owner; 0 when idle.
- ram_address_o  output  G  to Ram address_i.
- ram_data_o  output  32  to Ram data_i.
- ram_EN_o  output  1  to Ram EN (write enable).
- ram_ByteMode_o  output  1  to Ram ByteMode_i.
- ram_data_i  input  32  from Ram data_o.

Behaviour:
- Ram model:
  - Read is combinational from address/ByteMode.
  - Write occurs on the CLK rising edge while EN=1.
  - Byte reads return the byte zero-extended.
- Reset values (all outputs registered):
  - ack0/ack1/err=0, rdata=0, gnt=00.
  - ram_address=0, ram_data=0, ram_EN=0, ram_ByteMode=0.
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample req0/req1 each edge.
  - If one request is high, grant it. If both are high, grant the one not equal to last_grant.
  - On the grant edge: latch we/byte/addr/wdata into the ram_* registers, set gnt, update last_grant, go to ACCESS.
  - ram_EN loads we only if the access is legal.
- Legality: word access (byte=0) with addr[1:0]!=0 is misaligned. For a misaligned access, ram_EN stays 0 and the err flag is latched.
- ACCESS (exactly 1 cycle):
  - Ram signals are stable for the whole cycle.
  - The write commits at the edge ending ACCESS.
  - At that edge, rdata_o <= ram_data_i for a legal read, else 0. Writes and errors return 0.
  - Go to RESP. ram_EN <= 0.
- RESP (exactly 1 cycle):
  - ack of the owner =1; err_o valid.
  - Go to IDLE; at that edge gnt <= 00, ack <= 0, err <= 0.
  - rdata holds until the next capture.
- Latency: req high before edge N, ACCESS during cycle N+1, ack during cycle N+2. Throughput is one access per 3 cycles.
- Handshake rules:
  - The request is committed at the grant edge. Dropping req or changing its fields afterwards does not affect the transaction.
  - Requester drops req in its ack cycle. A req still high in the IDLE cycle after RESP is a new transaction.
  - No arbitration occurs in ACCESS/RESP; requests wait.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1. A lone requester may be granted back-to-back.
- Simultaneous events: both req rising at the same edge is resolved by last_grant only.
- Reset mid-operation:
  - RST at any edge forces IDLE and reset values; no ack is issued for the aborted transaction.
  - A write whose ACCESS cycle coincides with the RST edge may still be committed by the Ram; that is accepted.
- Address wrap: none; the full G-bit address is passed unchanged.

Test Plan:
- Single word write then read, requester 0:
  - Write addr=8, wdata=0x88030201 → ram_EN=1 for exactly one cycle, ack0 two cycles after the request.
  - Read addr=8 → rdata=0x88030201, err=0.
- Byte write/read, requester 1:
  - Byte write addr=7, data=0x000000CC → read word addr=4 returns 0xCC030201, given prior word 0x44030201.
  - Byte read addr=7 → rdata=0x000000CC.
- Contention:
  - req0 and req1 asserted together from reset and held, dropped only in their own ack cycle → grant order 0,1,0,1.
  - No ack overlap; gnt always one-hot or 00.
- Misaligned word write, addr=6, requester 0 → ram_EN never asserted, ack0 with err=1, rdata=0; memory at 4 unchanged.
- Reset during ACCESS (read, addr=12) → next cycle gnt=00, no ack, all outputs at reset values; a following request is served normally.
- req dropped one cycle after grant (write addr=0, 0x11030201) → transaction still completes with ack; the readback confirms the data.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared data Ram.
// The slave view belongs to the arbiter. The master view belongs to whatever
// drives the requests and models the Ram.
interface ram_arbiter_if #(
    parameter int G = 18
);
    // Requester 0 (CPU data port)
    logic          req0_i;
    logic          we0_i;
    logic          byte0_i;
    logic [G-1:0]  addr0_i;
    logic [31:0]   wdata0_i;
    logic          ack0_o;

    // Requester 1 (DMA/video port)
    logic          req1_i;
    logic          we1_i;
    logic          byte1_i;
    logic [G-1:0]  addr1_i;
    logic [31:0]   wdata1_i;
    logic          ack1_o;

    // Shared response
    logic          err_o;
    logic [31:0]   rdata_o;
    logic [1:0]    gnt_o;

    // Ram side
    logic [G-1:0]  ram_address_o;
    logic [31:0]   ram_data_o;
    logic          ram_EN_o;
    logic          ram_ByteMode_o;
    logic [31:0]   ram_data_i;

    modport slave (
        input  req0_i, we0_i, byte0_i, addr0_i, wdata0_i,
        input  req1_i, we1_i, byte1_i, addr1_i, wdata1_i,
        output ack0_o, ack1_o, err_o, rdata_o, gnt_o,
        output ram_address_o, ram_data_o, ram_EN_o, ram_ByteMode_o,
        input  ram_data_i
    );

    modport master (
        output req0_i, we0_i, byte0_i, addr0_i, wdata0_i,
        output req1_i, we1_i, byte1_i, addr1_i, wdata1_i,
        input  ack0_o, ack1_o, err_o, rdata_o, gnt_o,
        input  ram_address_o, ram_data_o, ram_EN_o, ram_ByteMode_o,
        output ram_data_i
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared 32-bit data
// Ram. A granted request is latched, presented to the Ram for exactly one
// ACCESS cycle, and answered with a one-cycle ack in RESP (IDLE->ACCESS->RESP).
module ram_arbiter #(
    parameter int G = 18
) (
    input  logic         CLK,
    input  logic         RST,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    // Index of the requester granted most recently. The reset value of 1 lets
    // requester 0 win the first tie.
    logic          r_last_grant;
    logic          r_we;
    logic          r_err_pend;

    logic [1:0]    r_gnt;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [G-1:0]  r_ram_address;
    logic [31:0]   r_ram_data;
    logic          r_ram_en;
    logic          r_ram_byte;

    logic          w_pick0;
    logic          w_pick1;
    logic          w_grant;
    logic          w_we;
    logic          w_byte;
    logic          w_mis;
    logic [G-1:0]  w_addr;
    logic [31:0]   w_wdata;

    // Round-robin choice between the two requesters and a mux of the winner's fields
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        w_pick1 = bus.req1_i && (!bus.req0_i || !r_last_grant);
        w_pick0 = bus.req0_i && !w_pick1;
        w_grant = (r_state == IDLE) && (w_pick0 || w_pick1);
        w_we    = w_pick1 ? bus.we1_i    : bus.we0_i;
        w_byte  = w_pick1 ? bus.byte1_i  : bus.byte0_i;
        w_addr  = w_pick1 ? bus.addr1_i  : bus.addr0_i;
        w_wdata = w_pick1 ? bus.wdata1_i : bus.wdata0_i;
        // A word access must be aligned to a 4-byte boundary
        w_mis   = !w_byte && (w_addr[1:0] != 2'b00);
    end

    // State register
    always_ff @(posedge CLK) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the values from before the edge.
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: only IDLE arbitrates, ACCESS and RESP last one cycle each
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_grant) w_next_state = ACCESS;
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch at grant, capture read data after ACCESS, release after RESP
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_grant  <= 1'b1;
            r_we          <= 1'b0;
            r_err_pend    <= 1'b0;
            r_gnt         <= 2'b00;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_en      <= 1'b0;
            r_ram_byte    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_ram_address <= w_addr;
                        r_ram_data    <= w_wdata;
                        r_ram_byte    <= w_byte;
                        // A misaligned access never reaches the Ram as a write
                        r_ram_en      <= w_we && !w_mis;
                        r_we          <= w_we;
                        r_err_pend    <= w_mis;
                        r_gnt         <= {w_pick1, w_pick0};
                        r_last_grant  <= w_pick1;
                    end
                end
                ACCESS: begin
                    // The Ram commits a write at this edge, so EN drops now
                    r_ram_en <= 1'b0;
                    r_rdata  <= (!r_we && !r_err_pend) ? bus.ram_data_i : 32'd0;
                    r_ack0   <= r_gnt[0];
                    r_ack1   <= r_gnt[1];
                    r_err    <= r_err_pend;
                end
                RESP: begin
                    // rdata is left alone so it holds until the next capture
                    r_gnt  <= 2'b00;
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt_o          = r_gnt;
    assign bus.ack0_o         = r_ack0;
    assign bus.ack1_o         = r_ack1;
    assign bus.err_o          = r_err;
    assign bus.rdata_o        = r_rdata;
    assign bus.ram_address_o  = r_ram_address;
    assign bus.ram_data_o     = r_ram_data;
    assign bus.ram_EN_o       = r_ram_en;
    assign bus.ram_ByteMode_o = r_ram_byte;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a little-endian Ram model, single transfers
// on both ports, contention, misalignment, reset mid-access and early req drop.
module tb_ram_arbiter;

    localparam int G = 18;

    logic clk;
    logic rst;
    int   n_vectors;
    int   n_miscompares;

    ram_arbiter_if #(.G(G)) bus ();

    ram_arbiter #(.G(G)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ram model: 64 words, combinational read, write on the rising edge with EN
    logic [31:0] mem [0:63];
    logic [5:0]  w_idx;
    logic [31:0] w_word;

    assign w_idx  = bus.ram_address_o[7:2];
    assign w_word = mem[w_idx] >> {bus.ram_address_o[1:0], 3'b000};

    always_comb begin
        bus.ram_data_i = mem[w_idx];
        if (bus.ram_ByteMode_o) bus.ram_data_i = {24'd0, w_word[7:0]};
    end

    always @(posedge clk) begin
        if (bus.ram_EN_o) begin
            if (bus.ram_ByteMode_o)
                mem[w_idx][{bus.ram_address_o[1:0], 3'b000} +: 8] <= bus.ram_data_o[7:0];
            else
                mem[w_idx] <= bus.ram_data_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic we, input logic bm,
                         input logic [G-1:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            bus.req0_i = req; bus.we0_i = we; bus.byte0_i = bm;
            bus.addr0_i = addr; bus.wdata0_i = wd;
        end else begin
            bus.req1_i = req; bus.we1_i = we; bus.byte1_i = bm;
            bus.addr1_i = addr; bus.wdata1_i = wd;
        end
    endtask

    function automatic logic gnt_legal();
        return (bus.gnt_o == 2'b00) || (bus.gnt_o == 2'b01) || (bus.gnt_o == 2'b10);
    endfunction

    // One transaction: request at a negedge, expect the ack on the second
    // negedge after it. With drop_early the requester withdraws and scrambles
    // its fields in the ACCESS cycle.
    task automatic txn(input string tag, input int port, input logic we, input logic bm,
                       input logic [G-1:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_en, input logic drop_early);
        int   n_cyc;
        int   en_cnt;
        logic got;
        logic gnt_ok;
        logic other_ack;
        n_cyc = 0; en_cnt = 0; got = 1'b0; gnt_ok = 1'b1; other_ack = 1'b0;
        @(negedge clk);
        drive(port, 1'b1, we, bm, addr, wd);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            n_cyc++;
            if (bus.ram_EN_o) en_cnt++;
            if (!gnt_legal()) gnt_ok = 1'b0;
            if (drop_early && n_cyc == 1) drive(port, 1'b0, ~we, 1'b0, addr ^ 18'h4, 32'hFFFF_FFFF);
            if ((port == 0) ? bus.ack0_o : bus.ack1_o) begin
                got = 1'b1;
                other_ack = (port == 0) ? bus.ack1_o : bus.ack0_o;
                check({tag, "_rdata"}, bus.rdata_o, exp_rdata);
                check({tag, "_err"}, bus.err_o, exp_err);
            end
        end
        check({tag, "_acked"}, got, 1'b1);
        check({tag, "_latency"}, n_cyc, 2);
        check({tag, "_en_cycles"}, en_cnt, exp_en);
        check({tag, "_gnt_onehot"}, gnt_ok, 1'b1);
        check({tag, "_other_ack"}, other_ack, 1'b0);
        if (port == 0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   bus.gnt_o, 2'b00);
        check({tag, "_ack0"},  bus.ack0_o, 1'b0);
        check({tag, "_ack1"},  bus.ack1_o, 1'b0);
        check({tag, "_err"},   bus.err_o, 1'b0);
        check({tag, "_rdata"}, bus.rdata_o, 32'd0);
        check({tag, "_addr"},  bus.ram_address_o, 18'd0);
        check({tag, "_wdata"}, bus.ram_data_o, 32'd0);
        check({tag, "_en"},    bus.ram_EN_o, 1'b0);
        check({tag, "_bmode"}, bus.ram_ByteMode_o, 1'b0);
    endtask

    initial begin
        int   order [4];
        int   nack;
        logic stray_ack;

        n_vectors = 0;
        n_miscompares = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Word write/read on port 0
        txn("p0_wr8", 0, 1'b1, 1'b0, 18'd8, 32'h8803_0201, 32'd0, 1'b0, 1, 1'b0);
        txn("p0_rd8", 0, 1'b0, 1'b0, 18'd8, 32'd0, 32'h8803_0201, 1'b0, 0, 1'b0);

        // Byte write into an existing word on port 1
        txn("p1_wr4",  1, 1'b1, 1'b0, 18'd4, 32'h4403_0201, 32'd0, 1'b0, 1, 1'b0);
        txn("p1_bwr7", 1, 1'b1, 1'b1, 18'd7, 32'h0000_00CC, 32'd0, 1'b0, 1, 1'b0);
        txn("p1_rd4",  1, 1'b0, 1'b0, 18'd4, 32'd0, 32'hCC03_0201, 1'b0, 0, 1'b0);
        txn("p1_brd7", 1, 1'b0, 1'b1, 18'd7, 32'd0, 32'h0000_00CC, 1'b0, 0, 1'b0);

        // Misaligned word write: no Ram write, err with ack, word 4 untouched
        txn("p0_mis6", 0, 1'b1, 1'b0, 18'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, 0, 1'b0);
        txn("p0_rd4",  0, 1'b0, 1'b0, 18'd4, 32'd0, 32'hCC03_0201, 1'b0, 0, 1'b0);

        // Contention from reset: both held, each re-raised after its own ack
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 18'd8, 32'd0);
        drive(1, 1'b1, 1'b0, 1'b0, 18'd4, 32'd0);
        nack = 0;
        for (int cyc = 0; cyc < 40 && nack < 4; cyc++) begin
            @(negedge clk);
            check("cont_no_overlap", bus.ack0_o & bus.ack1_o, 1'b0);
            check("cont_gnt_legal", gnt_legal(), 1'b1);
            if (bus.ack0_o) begin
                order[nack] = 0;
                nack++;
                check("cont_rdata0", bus.rdata_o, 32'h8803_0201);
                bus.req0_i = 1'b0;
            end else begin
                bus.req0_i = 1'b1;
            end
            if (bus.ack1_o) begin
                order[nack] = 1;
                nack++;
                check("cont_rdata1", bus.rdata_o, 32'hCC03_0201);
                bus.req1_i = 1'b0;
            end else begin
                bus.req1_i = 1'b1;
            end
        end
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        check("cont_ack_count", nack, 4);
        if (nack == 4) begin
            check("cont_order0", order[0], 0);
            check("cont_order1", order[1], 1);
            check("cont_order2", order[2], 0);
            check("cont_order3", order[3], 1);
        end
        repeat (2) @(negedge clk);

        // Reset while a read of address 12 is in ACCESS
        drive(0, 1'b1, 1'b0, 1'b0, 18'd12, 32'd0);
        @(negedge clk);
        check("rst_mid_gnt_access", bus.gnt_o, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0_i = 1'b0;
        check_reset_outputs("rst_mid");
        stray_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ack0_o || bus.ack1_o) stray_ack = 1'b1;
        end
        check("rst_mid_no_ack", stray_ack, 1'b0);
        txn("after_rst_rd8", 0, 1'b0, 1'b0, 18'd8, 32'd0, 32'h8803_0201, 1'b0, 0, 1'b0);

        // req withdrawn in ACCESS: the latched write still completes
        txn("drop_wr0", 0, 1'b1, 1'b0, 18'd0, 32'h1103_0201, 32'd0, 1'b0, 1, 1'b1);
        txn("drop_rd0", 0, 1'b0, 1'b0, 18'd0, 32'd0, 32'h1103_0201, 1'b0, 0, 1'b0);
        txn("drop_rd4", 1, 1'b0, 1'b0, 18'd4, 32'd0, 32'hCC03_0201, 1'b0, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
